// File: rtl/adder_bist_pkg.sv
// Shared types and LFSR helper for the adder BIST controller.
// Galois step for x^64+x^63+x^61+x^60+1, shifting right.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAPS : 64'h0);
    endfunction

endpackage

// File: rtl/bist_lfsr64.sv
// 64-bit Galois LFSR state holder.
// Exposes the next two step values so one operand pair is drawn per advance.
module bist_lfsr64
    import adder_bist_pkg::*;
#(
    parameter logic [63:0] RST_VAL = 64'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        adv2,
    output logic [63:0] s1,
    output logic [63:0] s2
);

    logic [63:0] r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RST_VAL;
        else if (load)
            r_state <= seed;
        else if (adv2)
            r_state <= s2;
    end

    assign s1 = lfsr_step(r_state);
    assign s2 = lfsr_step(s1);

endmodule

// File: rtl/adder_bist_ctrl.sv
// Stimulus/check controller for one combinational adder under test:
// draws LFSR operand pairs, waits SETTLE cycles, compares against a+b.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          NUM_TESTS = 1000,
    parameter int          SETTLE    = 2,
    parameter logic [63:0] SEED      = 64'h5,
    parameter int          CW        = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] cut_sum,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pass_cnt,
    output logic [CW-1:0]    fail_cnt,
    output logic             fail_seen,
    output logic [CW-1:0]    ff_idx,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic [WIDTH-1:0] ff_sum
);

    localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam int          SCW      = $clog2(SETTLE + 1);

    state_t           r_state, w_next;
    logic [SCW-1:0]   r_settle;
    logic [CW-1:0]    r_idx, r_pass, r_fail, r_ff_idx;
    logic [WIDTH-1:0] r_a, r_b, r_ff_a, r_ff_b, r_ff_sum;
    logic             r_fail_seen;
    logic [63:0]      w_s1, w_s2;
    logic [WIDTH-1:0] w_ref;
    logic             w_start_run, w_last;
    logic             w_unused;

    assign w_start_run = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last      = (r_idx == CW'(NUM_TESTS - 1));
    assign w_ref       = r_a + r_b;
    assign w_unused    = ^{w_s1, w_s2};

    bist_lfsr64 #(
        .RST_VAL(SEED_EFF)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_run),
        .seed (SEED_EFF),
        .adv2 (r_state == ST_LOAD),
        .s1   (w_s1),
        .s2   (w_s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_LOAD;
            ST_LOAD:          w_next = ST_SETTLE;
            ST_SETTLE:        if (r_settle == SCW'(1)) w_next = ST_CHECK;
            ST_CHECK:         w_next = w_last ? ST_DONE : ST_LOAD;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle    <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_fail_seen <= 1'b0;
            r_ff_idx    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_ff_sum    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_pass      <= '0;
                        r_fail      <= '0;
                        r_fail_seen <= 1'b0;
                        r_ff_idx    <= '0;
                        r_ff_a      <= '0;
                        r_ff_b      <= '0;
                        r_ff_sum    <= '0;
                    end
                end
                ST_LOAD: begin
                    r_a      <= w_s1[WIDTH-1:0];
                    r_b      <= w_s2[WIDTH-1:0];
                    r_settle <= SCW'(SETTLE);
                end
                ST_SETTLE: r_settle <= r_settle - SCW'(1);
                ST_CHECK: begin
                    if (cut_sum == w_ref) begin
                        r_pass <= r_pass + CW'(1);
                    end else begin
                        r_fail <= r_fail + CW'(1);
                        // Only the first mismatch of a run is captured.
                        if (!r_fail_seen) begin
                            r_fail_seen <= 1'b1;
                            r_ff_idx    <= r_idx;
                            r_ff_a      <= r_a;
                            r_ff_b      <= r_b;
                            r_ff_sum    <= cut_sum;
                        end
                    end
                    r_idx <= r_idx + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass_cnt  = r_pass;
    assign fail_cnt  = r_fail;
    assign fail_seen = r_fail_seen;
    assign ff_idx    = r_ff_idx;
    assign ff_a      = r_ff_a;
    assign ff_b      = r_ff_b;
    assign ff_sum    = r_ff_sum;

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- Sequential stimulus/check stage wrapped around one combinational adder under test (prefix, Jackson or Ling; 8/16/32/64-bit).
- Generates pseudo-random operand pairs from a 64-bit LFSR and drives them into the adder.
- Waits a programmable settle time, then compares the adder's sum against an internal `a+b` reference.
- Accumulates pass/fail counts and captures the first failing vector; gives on-chip/FPGA self-test of the adder family.

Parameters:
- WIDTH, 32, operand/sum width; legal 8, 16, 32, 64.
- NUM_TESTS, 1000, vectors per run; >=1.
- SETTLE, 2, cycles the adder inputs are held before sampling; >=1.
- SEED, 64'h5, LFSR reload value; a value of 0 is replaced by 64'h1.
- CW, $clog2(NUM_TESTS+1), counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request
- a_out  out  WIDTH  operand A to the adder under test
- b_out  out  WIDTH  operand B to the adder under test
- cut_sum  in  WIDTH  sum returned by the adder under test
- busy  out  1  high from LOAD through CHECK
- done  out  1  high in DONE
- pass_cnt  out  CW  matching vectors
- fail_cnt  out  CW  mismatching vectors
- fail_seen  out  1  sticky: at least one mismatch this run
- ff_idx  out  CW  index of first failing vector
- ff_a  out  WIDTH  A of first failing vector
- ff_b  out  WIDTH  B of first failing vector
- ff_sum  out  WIDTH  cut_sum of first failing vector

Behaviour:
- Reset (async, rst=1):
  - State IDLE; LFSR=SEED.
  - All outputs 0; test index and settle counter 0.
- LFSR: Galois, polynomial x^64+x^63+x^61+x^60+1; one step = one shift.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → clear pass_cnt, fail_cnt, fail_seen, ff_*, idx; reload LFSR=SEED; next LOAD.
- LOAD (1 cycle):
  - s1=step(lfsr), s2=step(s1).
  - a_out<=s1[WIDTH-1:0], b_out<=s2[WIDTH-1:0]; lfsr<=s2.
  - settle counter<=SETTLE; next SETTLE.
- SETTLE:
  - Counter decrements each cycle; a_out/b_out held stable.
  - Counter==1 → next CHECK. Exactly SETTLE cycles.
- CHECK (1 cycle):
  - ref=(a_out+b_out) mod 2^WIDTH; carry-out is discarded.
  - cut_sum==ref → pass_cnt+1.
  - Else fail_cnt+1. If fail_seen==0: set fail_seen; ff_idx<=idx, ff_a<=a_out, ff_b<=b_out, ff_sum<=cut_sum.
  - idx+1.
  - idx==NUM_TESTS-1 → next DONE, else LOAD.
- Timing: each vector takes SETTLE+2 cycles. DONE is entered NUM_TESTS*(SETTLE+2) cycles after LOAD is first entered.
- DONE:
  - done=1; counters and ff_* held; a_out/b_out held at last vector.
  - start=1 → same action as start in IDLE, next LOAD. done drops the cycle LOAD is entered.
- start while busy is ignored, with no effect on state or counters.
- Invariant: pass_cnt+fail_cnt==idx at all times; no counter wraps (CW sized for NUM_TESTS).
- Restarting with the same SEED reproduces an identical operand sequence.
- rst mid-run aborts immediately to the reset state; there is no partial-result retention.
- cut_sum is sampled only in CHECK; its value in other states is don't-care.

Decomposition:
- Package adder_bist_pkg:
  - state enum {IDLE, LOAD, SETTLE, CHECK, DONE};
  - LFSR tap constant 64'hD800_0000_0000_0000;
  - function lfsr_step(64b)→64b.
- Sub-module bist_lfsr64: holds the 64-bit state; inputs load, seed, adv2; outputs s1, s2 (the next two step values).
- FSM, counters, reference compare and first-fail capture live in adder_bist_ctrl.

Test Plan:
- Golden run: WIDTH=16, NUM_TESTS=16, SETTLE=1, cut_sum tied to the mod16_adder output → pass_cnt=16, fail_cnt=0, fail_seen=0; done rises 48 cycles after LOAD entry.
- Stuck fault: WIDTH=8, cut_sum[0] forced to 0 → fail_cnt equals the bench-model count of odd sums; ff_idx/ff_a/ff_b match the first odd-sum vector; ff_sum[0]=0.
- Wrap check: WIDTH=8, NUM_TESTS=1000, reference mod8_adder → fail_cnt=0. Bench confirms at least one vector with a_out+b_out>255 (carry discarded correctly).
- start ignored while busy: pulse start mid-SETTLE of vector 3 → idx, pass_cnt and operand sequence identical to an undisturbed run.
- Async reset: assert rst during CHECK of vector 5, same cycle → all outputs 0 and state IDLE before the next edge. A following start yields the same first operands as the golden run.
- Restart from DONE: second start after the golden run → counters cleared on LOAD entry, identical a_out/b_out sequence, final pass_cnt=16.
